dmem_mmio: RTL

DMEM_MMIO -- requirements
Module: dmem_mmio

---
 rtl/dmem_mmio_if.sv | 12 +
 rtl/dmem_mmio.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_if.sv
// Memory bus between the core and dmem_mmio: one access per cycle,
// combinational read data, writes committed on the rising clock edge.
interface dmem_mmio_if;
  logic        we;
  logic [3:0]  be;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, be, a, wd, input rd);
  modport slave  (input we, be, a, wd, output rd);
endinterface

// File: rtl/dmem_mmio.sv
// Data memory with a memory-mapped peripheral window: byte-lane RAM,
// switches, LEDs, 7-segment registers, debounced Enter key, cycle counter, fault capture.
module dmem_mmio #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned SW_W    = 10,
  parameter int unsigned LED_W   = 10,
  parameter int unsigned DEB_CYC = 4,
  parameter logic [31:0] IO_BASE = 32'hC000_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  dmem_mmio_if.slave       bus,
  input  logic [SW_W-1:0]  switches,
  input  logic             Enter,
  output logic [LED_W-1:0] leds,
  output logic [7:0]       disp_num,
  output logic [3:0]       disp_let,
  output logic             fault
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEB_CYC);

  localparam logic [2:0] OFF_SW    = 3'd0;
  localparam logic [2:0] OFF_LED   = 3'd1;
  localparam logic [2:0] OFF_DNUM  = 3'd2;
  localparam logic [2:0] OFF_DLET  = 3'd3;
  localparam logic [2:0] OFF_ENTER = 3'd4;
  localparam logic [2:0] OFF_CYC   = 3'd5;
  localparam logic [2:0] OFF_FADDR = 3'd6;

  logic [31:0]      mem_q [DEPTH];

  logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
  logic             en_s1_q, en_s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             flag_q, flag_d;
  logic [LED_W-1:0] leds_q, leds_d;
  logic [7:0]       dnum_q, dnum_d;
  logic [3:0]       dlet_q, dlet_d;
  logic [31:0]      cyc_q, cyc_d;
  logic             fault_q, fault_d;
  logic [31:0]      faddr_q, faddr_d;

  logic           ram_sel_c, io_sel_c, oor_c, io_we_c;
  logic [AW-1:0]  ram_idx_c;
  logic [2:0]     io_off_c;

  // Address decode; RAM wins if the IO window were ever placed inside it.
  assign ram_sel_c = (bus.a < 32'(4 * DEPTH));
  assign io_sel_c  = !ram_sel_c && (bus.a[31:5] == IO_BASE[31:5]);
  assign oor_c     = !ram_sel_c && !io_sel_c;
  assign io_we_c   = bus.we && io_sel_c;
  assign ram_idx_c = bus.a[AW+1:2];
  assign io_off_c  = bus.a[4:2];

  // RAM has no reset so its contents survive reset_n.
  always_ff @(posedge clk) begin
    if (bus.we && ram_sel_c) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.be[i]) mem_q[ram_idx_c][8*i +: 8] <= bus.wd[8*i +: 8];
      end
    end
  end

  // Read mux.
  always_comb begin
    bus.rd = 32'h0;
    if (ram_sel_c) begin
      bus.rd = mem_q[ram_idx_c];
    end else if (io_sel_c) begin
      case (io_off_c)
        OFF_SW:    bus.rd = 32'(sw_s2_q);
        OFF_LED:   bus.rd = 32'(leds_q);
        OFF_DNUM:  bus.rd = 32'(dnum_q);
        OFF_DLET:  bus.rd = 32'(dlet_q);
        OFF_ENTER: bus.rd = {30'h0, db_q, flag_q};
        OFF_CYC:   bus.rd = cyc_q;
        OFF_FADDR: bus.rd = faddr_q;
        default:   bus.rd = 32'h0;
      endcase
    end
  end

  // Next-state for registers, debouncer, press flag and fault capture.
  always_comb begin
    leds_d  = leds_q;
    dnum_d  = dnum_q;
    dlet_d  = dlet_q;
    cyc_d   = cyc_q + 32'd1;
    cnt_d   = cnt_q;
    db_d    = db_q;
    flag_d  = flag_q;
    fault_d = fault_q;
    faddr_d = faddr_q;

    if (io_we_c) begin
      case (io_off_c)
        OFF_LED:  leds_d = bus.wd[LED_W-1:0];
        OFF_DNUM: dnum_d = bus.wd[7:0];
        OFF_DLET: dlet_d = bus.wd[3:0];
        OFF_CYC:  cyc_d  = bus.wd;
        default:  ;
      endcase
    end

    if (en_s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
      db_d  = ~db_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A rising edge of the debounced level outranks a same-cycle clear.
    if (io_we_c && (io_off_c == OFF_ENTER) && bus.wd[0]) flag_d = 1'b0;
    if (db_d && !db_q) flag_d = 1'b1;

    if (oor_c && bus.we) begin
      fault_d = 1'b1;
      if (!fault_q) faddr_d = bus.a;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      en_s1_q <= 1'b0;
      en_s2_q <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      flag_q  <= 1'b0;
      leds_q  <= '0;
      dnum_q  <= '0;
      dlet_q  <= '0;
      cyc_q   <= '0;
      fault_q <= 1'b0;
      faddr_q <= '0;
    end else begin
      sw_s1_q <= switches;
      sw_s2_q <= sw_s1_q;
      en_s1_q <= Enter;
      en_s2_q <= en_s1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      flag_q  <= flag_d;
      leds_q  <= leds_d;
      dnum_q  <= dnum_d;
      dlet_q  <= dlet_d;
      cyc_q   <= cyc_d;
      fault_q <= fault_d;
      faddr_q <= faddr_d;
    end
  end

  assign leds     = leds_q;
  assign disp_num = dnum_q;
  assign disp_let = dlet_q;
  assign fault    = fault_q;

endmodule
